capture_dma_ctrl: RTL and testbench
===================================

CAPTURE_DMA_CTRL -- requirements
Module: capture_dma_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 16, byte-address width of the SRAM DMA write port.
REQ-002 SHALL have parameter SLOT_W, default 4, width of the frame-slot index.
REQ-003 SHALL have port clk  in  1  sole clock; all logic on posedge clk.
REQ-004 SHALL have port rst  in  1  synchronous, active-high reset.
REQ-005 SHALL have port start  in  1  one-cycle pulse; latches config and arms capture.
REQ-006 SHALL have port abort  in  1  one-cycle pulse; returns to IDLE.
REQ-007 SHALL have port cfg_base  in  ADDR_W  byte address of slot 0.
REQ-008 SHALL have port cfg_len  in  ADDR_W  bytes per frame slot; 0 is treated as 1.
REQ-009 SHALL have port cfg_slots  in  SLOT_W  number of ring slots; 0 is treated as 1.
REQ-010 SHALL have port cfg_single  in  1  1 = stop after one frame; 0 = continuous ring.
REQ-011 SHALL have ports pix_valid/pix_sof/pix_eof  in  1 each, and pix_data  in  8; these form the camera byte stream.
REQ-012 SHALL have port pix_ready  out  1  stream ready.
REQ-013 SHALL have ports dma_wr_en  out  1, dma_wr_addr  out  ADDR_W, and dma_wr_data  out  8; these drive the SRAM byte write port.
REQ-014 SHALL have ports busy  out  1, frame_done  out  1 (pulse), slot_idx  out  SLOT_W, err_long  out  1 (sticky), and err_short  out  1 (sticky).

Function
REQ-015 SHALL implement states IDLE, WAIT_SOF, CAPTURE; busy = (state != IDLE).
REQ-016 SHALL drive pix_ready = 1 in WAIT_SOF and CAPTURE, and 0 in IDLE.
REQ-017 SHALL, on start in IDLE, latch cfg_* and clear slot_idx, slot base (= cfg_base), err_long and err_short, then enter WAIT_SOF next cycle.
REQ-018 SHALL ignore start while busy.
REQ-019 SHALL, in WAIT_SOF, discard accepted beats (pix_valid & pix_ready) without pix_sof.
REQ-020 SHALL treat a beat with pix_sof as byte offset 0 and enter CAPTURE.
REQ-021 SHALL, for each byte written, assert dma_wr_en exactly one cycle after acceptance, with dma_wr_addr = slot_base + offset (mod 2^ADDR_W) and dma_wr_data = pix_data.
REQ-022 SHALL compute slot_base incrementally by adding cfg_len on slot advance; no multiplier.
REQ-023 SHALL end the frame on the accepted beat where offset == cfg_len-1 or pix_eof is set, whichever comes first; that beat itself is written.
REQ-024 SHALL set err_short if pix_eof arrives at offset < cfg_len-1.
REQ-025 SHALL set err_long and write nothing further if a frame reaches cfg_len bytes without pix_eof; the remaining bytes up to and including pix_eof are discarded (WAIT_SOF semantics) before the next SOF is honoured.
REQ-026 SHALL pulse frame_done for one cycle, coincident with the last byte's dma_wr_en.
REQ-027 SHALL, on frame end, advance slot_idx (wrapping to 0 and slot_base to cfg_base at cfg_slots-1) and go to WAIT_SOF, or to IDLE if cfg_single.
REQ-028 SHALL treat a pix_sof seen mid-CAPTURE as a new frame: the current frame ends with err_short, the slot advances, and the SOF byte is offset 0 of the next slot.
REQ-029 SHALL give abort priority over start and the stream: a beat in the abort cycle is not written, state → IDLE next cycle, no frame_done, and slot_idx/errors hold.
REQ-030 SHALL keep dma_wr_en 0 whenever no byte was accepted the previous cycle.

Reset
REQ-031 SHALL, on rst, set state = IDLE, dma_wr_en = 0, dma_wr_addr = 0, dma_wr_data = 0, frame_done = 0, slot_idx = 0, err_long = 0, err_short = 0, and busy = 0.
REQ-032 SHALL give rst priority over all inputs; rst mid-CAPTURE issues no further writes.

Structure
REQ-033 SHALL place the state enum cap_state_t and SLOT_W default in package dashcam_dma_pkg.
REQ-034 SHALL implement the slot index/base ring pointer as sub-module capture_slot_ptr (inputs: load, advance, cfg_base, cfg_len, cfg_slots; outputs: slot_idx, slot_base).

Verification
REQ-035 SHALL cover nominal capture: base=0x1000, len=4, slots=2, single=0; frames bytes AA..AD, then 11..14 → writes 0x1000-0x1003, then 0x1004-0x1007; frame_done twice; slot_idx 0→1→0.
REQ-036 SHALL cover ring wrap: base=0xFFFE, len=4, slots=1 → addresses FFFE, FFFF, 0000, 0001; the second frame restarts at FFFE.
REQ-037 SHALL cover a short frame: len=8, eof on 3rd byte → 3 writes, err_short=1, frame_done on 3rd write.
REQ-038 SHALL cover a long frame: len=2, 5 bytes then eof → 2 writes, err_long=1, next SOF frame written at base+2.
REQ-039 SHALL cover abort during CAPTURE after 2 bytes, with a byte in the abort cycle → exactly 2 writes, busy=0 next cycle, no frame_done.
REQ-040 SHALL cover pre-SOF garbage and reset: 3 non-SOF beats in WAIT_SOF → no writes; rst mid-frame → all outputs at reset values, no writes after.

Source files
------------

// File: rtl/dashcam_dma_pkg.sv
// Shared types for the dashcam capture DMA controller.
//   cap_state_t : controller state encoding
//   SLOT_W_DEF  : default width of the frame-slot index
package dashcam_dma_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_SOF = 2'd1,
    ST_CAPTURE  = 2'd2
  } cap_state_t;

  localparam int SLOT_W_DEF = 4;

endpackage

// File: rtl/capture_slot_ptr.sv
// Ring pointer over the frame slots: holds the current slot index and the byte
// address of that slot's first byte. The base is stepped by adding cfg_len, so
// no multiplier is needed.
// Ports:
//   clk, rst              : clock, synchronous active-high reset
//   load                  : restart at slot 0 / cfg_base
//   advance               : step one slot
//   advance2              : step two slots in one cycle (takes precedence)
//   cfg_base/len/slots    : ring geometry (cfg_slots of 0 behaves as 1)
//   slot_idx, slot_base   : current slot
//   base_nxt              : base of the slot one step ahead
module capture_slot_ptr
  import dashcam_dma_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int SLOT_W = SLOT_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              advance,
  input  logic              advance2,
  input  logic [ADDR_W-1:0] cfg_base,
  input  logic [ADDR_W-1:0] cfg_len,
  input  logic [SLOT_W-1:0] cfg_slots,
  output logic [SLOT_W-1:0] slot_idx,
  output logic [ADDR_W-1:0] slot_base,
  output logic [ADDR_W-1:0] base_nxt
);

  logic [SLOT_W-1:0] idx_q, idx_1, idx_2, last_idx;
  logic [ADDR_W-1:0] base_q, base_1, base_2;

  always_comb begin
    last_idx = (cfg_slots == '0) ? '0 : cfg_slots - SLOT_W'(1);
    idx_1    = (idx_q == last_idx) ? '0 : idx_q + SLOT_W'(1);
    base_1   = (idx_q == last_idx) ? cfg_base : base_q + cfg_len;
    idx_2    = (idx_1 == last_idx) ? '0 : idx_1 + SLOT_W'(1);
    base_2   = (idx_1 == last_idx) ? cfg_base : base_1 + cfg_len;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q  <= '0;
      base_q <= '0;
    end else if (load) begin
      idx_q  <= '0;
      base_q <= cfg_base;
    end else if (advance2) begin
      idx_q  <= idx_2;
      base_q <= base_2;
    end else if (advance) begin
      idx_q  <= idx_1;
      base_q <= base_1;
    end
  end

  assign slot_idx  = idx_q;
  assign slot_base = base_q;
  assign base_nxt  = base_1;

endmodule

// File: rtl/capture_dma_ctrl.sv
// Camera byte stream to SRAM ring-buffer capture controller.
// Ports:
//   clk, rst                   : clock, synchronous active-high reset
//   start, abort               : arm capture (latches cfg_*), return to idle
//   cfg_base/len/slots/single  : ring geometry and single-frame mode
//   pix_valid/sof/eof/data     : camera byte stream, pix_ready back-pressure
//   dma_wr_en/addr/data        : SRAM byte write port, one cycle after accept
//   busy, frame_done, slot_idx : status; err_long/err_short are sticky
//
// state       | meaning
// ST_IDLE     | not armed, stream not accepted
// ST_WAIT_SOF | armed, discarding beats until a start of frame
// ST_CAPTURE  | writing bytes of the current frame
module capture_dma_ctrl
  import dashcam_dma_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int SLOT_W = SLOT_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] cfg_base,
  input  logic [ADDR_W-1:0] cfg_len,
  input  logic [SLOT_W-1:0] cfg_slots,
  input  logic              cfg_single,
  input  logic              pix_valid,
  input  logic              pix_sof,
  input  logic              pix_eof,
  input  logic [7:0]        pix_data,
  output logic              pix_ready,
  output logic              dma_wr_en,
  output logic [ADDR_W-1:0] dma_wr_addr,
  output logic [7:0]        dma_wr_data,
  output logic              busy,
  output logic              frame_done,
  output logic [SLOT_W-1:0] slot_idx,
  output logic              err_long,
  output logic              err_short
);

  localparam logic [ADDR_W-1:0] ONE = ADDR_W'(1);

  cap_state_t        state_q, state_d;
  logic [ADDR_W-1:0] len_q, len_d, base_q, base_d, off_q, off_d;
  logic [SLOT_W-1:0] slots_q, slots_d;
  logic              single_q, single_d, drop_q, drop_d;
  logic              err_long_q, err_long_d, err_short_q, err_short_d;
  logic              wr_en_q, wr_en_d, frame_done_q, frame_done_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [7:0]        wr_data_q, wr_data_d;

  logic              ptr_load, ptr_adv, ptr_adv2;
  logic [ADDR_W-1:0] slot_base, base_nxt, len_m1, beat_off, beat_base;
  logic              accept, take, mid_sof;

  capture_slot_ptr #(
    .ADDR_W (ADDR_W),
    .SLOT_W (SLOT_W)
  ) u_slot_ptr (
    .clk       (clk),
    .rst       (rst),
    .load      (ptr_load),
    .advance   (ptr_adv),
    .advance2  (ptr_adv2),
    .cfg_base  (ptr_load ? cfg_base : base_q),
    .cfg_len   (len_q),
    .cfg_slots (slots_q),
    .slot_idx  (slot_idx),
    .slot_base (slot_base),
    .base_nxt  (base_nxt)
  );

  assign pix_ready = (state_q != ST_IDLE);
  assign accept    = pix_valid & pix_ready;
  assign len_m1    = len_q - ONE;

  always_comb begin
    state_d      = state_q;
    len_d        = len_q;
    slots_d      = slots_q;
    single_d     = single_q;
    base_d       = base_q;
    off_d        = off_q;
    drop_d       = drop_q;
    err_long_d   = err_long_q;
    err_short_d  = err_short_q;
    wr_en_d      = 1'b0;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    frame_done_d = 1'b0;
    ptr_load     = 1'b0;
    ptr_adv      = 1'b0;
    ptr_adv2     = 1'b0;
    take         = 1'b0;
    mid_sof      = 1'b0;
    beat_off     = '0;
    beat_base    = slot_base;

    if (abort) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (start) begin
            ptr_load    = 1'b1;
            len_d       = (cfg_len == '0) ? ONE : cfg_len;
            slots_d     = cfg_slots;
            single_d    = cfg_single;
            base_d      = cfg_base;
            off_d       = '0;
            drop_d      = 1'b0;
            err_long_d  = 1'b0;
            err_short_d = 1'b0;
            state_d     = ST_WAIT_SOF;
          end
        end
        ST_WAIT_SOF: begin
          if (accept) begin
            // after an over-long frame the tail is thrown away through its eof
            if (drop_q) begin
              if (pix_eof) drop_d = 1'b0;
            end else if (pix_sof) begin
              take = 1'b1;
            end
          end
        end
        ST_CAPTURE: begin
          if (accept) begin
            if (pix_sof) begin
              // early SOF: close the current frame short and restart in the next slot
              mid_sof     = 1'b1;
              err_short_d = 1'b1;
              ptr_adv     = 1'b1;
              if (single_q) begin
                state_d = ST_IDLE;
              end else begin
                take         = 1'b1;
                beat_base    = base_nxt;
                frame_done_d = 1'b1;
              end
            end else begin
              take     = 1'b1;
              beat_off = off_q;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase

      if (take) begin
        wr_en_d   = 1'b1;
        wr_addr_d = beat_base + beat_off;
        wr_data_d = pix_data;
        if (pix_eof || beat_off == len_m1) begin
          frame_done_d = 1'b1;
          off_d        = '0;
          if (!pix_eof) begin
            err_long_d = 1'b1;
            drop_d     = 1'b1;
          end else if (beat_off != len_m1) begin
            err_short_d = 1'b1;
          end
          // a one-beat frame opened by an early SOF closes two slots at once
          if (mid_sof) ptr_adv2 = 1'b1;
          else         ptr_adv  = 1'b1;
          state_d = single_q ? ST_IDLE : ST_WAIT_SOF;
        end else begin
          off_d   = beat_off + ONE;
          state_d = ST_CAPTURE;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      len_q        <= ONE;
      slots_q      <= '0;
      single_q     <= 1'b0;
      base_q       <= '0;
      off_q        <= '0;
      drop_q       <= 1'b0;
      err_long_q   <= 1'b0;
      err_short_q  <= 1'b0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      slots_q      <= slots_d;
      single_q     <= single_d;
      base_q       <= base_d;
      off_q        <= off_d;
      drop_q       <= drop_d;
      err_long_q   <= err_long_d;
      err_short_q  <= err_short_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign busy        = (state_q != ST_IDLE);
  assign dma_wr_en   = wr_en_q;
  assign dma_wr_addr = wr_addr_q;
  assign dma_wr_data = wr_data_q;
  assign frame_done  = frame_done_q;
  assign err_long    = err_long_q;
  assign err_short   = err_short_q;

endmodule

// File: tb/tb_capture_dma_ctrl.sv
// Self-checking bench for capture_dma_ctrl: expected SRAM writes are queued as
// beats are driven and popped by a monitor as the DMA port fires.
module tb_capture_dma_ctrl;

  logic        clk = 1'b0;
  logic        rst, start, abort, cfg_single;
  logic [15:0] cfg_base, cfg_len;
  logic [3:0]  cfg_slots;
  logic        pix_valid, pix_sof, pix_eof, pix_ready;
  logic [7:0]  pix_data;
  logic        dma_wr_en, busy, frame_done, err_long, err_short;
  logic [15:0] dma_wr_addr;
  logic [7:0]  dma_wr_data;
  logic [3:0]  slot_idx;

  int n_checks = 0;
  int n_err    = 0;

  typedef struct {
    logic [15:0] addr;
    logic [7:0]  data;
    logic        done;
    logic        chk_done;
  } wr_t;
  wr_t sb_q[$];

  typedef struct {
    logic [15:0] base;
    logic [15:0] len;
    logic [3:0]  slots;
    int          nbytes;
    int          nwr;
    logic        short_e;
    logic        long_e;
    logic [3:0]  slot_e;
  } vec_t;
  vec_t vecs[6];

  capture_dma_ctrl #(.ADDR_W(16), .SLOT_W(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .abort       (abort),
    .cfg_base    (cfg_base),
    .cfg_len     (cfg_len),
    .cfg_slots   (cfg_slots),
    .cfg_single  (cfg_single),
    .pix_valid   (pix_valid),
    .pix_sof     (pix_sof),
    .pix_eof     (pix_eof),
    .pix_data    (pix_data),
    .pix_ready   (pix_ready),
    .dma_wr_en   (dma_wr_en),
    .dma_wr_addr (dma_wr_addr),
    .dma_wr_data (dma_wr_data),
    .busy        (busy),
    .frame_done  (frame_done),
    .slot_idx    (slot_idx),
    .err_long    (err_long),
    .err_short   (err_short)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (dma_wr_en === 1'b1) begin
      n_checks++;
      if (sb_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_write: addr=%h data=%h, no write expected", dma_wr_addr, dma_wr_data);
      end else begin
        wr_t e;
        e = sb_q.pop_front();
        if (dma_wr_addr !== e.addr || dma_wr_data !== e.data || (e.chk_done && frame_done !== e.done)) begin
          n_err++;
          $display("FAIL write: got addr=%h data=%h done=%b, expected addr=%h data=%h done=%b",
                   dma_wr_addr, dma_wr_data, frame_done, e.addr, e.data, e.done);
        end
      end
    end else if (frame_done === 1'b1) begin
      n_checks++;
      n_err++;
      $display("FAIL stray_frame_done: frame_done=1 without dma_wr_en");
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic start_cfg(input logic [15:0] b, input logic [15:0] l, input logic [3:0] s, input logic sg);
    cfg_base = b; cfg_len = l; cfg_slots = s; cfg_single = sg;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send(input logic [7:0] d, input logic sof, input logic eof, input logic wr,
                      input logic [15:0] a, input logic done, input logic cd);
    pix_valid = 1'b1; pix_data = d; pix_sof = sof; pix_eof = eof;
    if (wr) sb_q.push_back('{a, d, done, cd});
    tick();
    pix_valid = 1'b0; pix_sof = 1'b0; pix_eof = 1'b0;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (sb_q.size() != 0 && n < 20) begin
      tick();
      n++;
    end
    tick();
    tick();
    chk(name, sb_q.size(), 0);
    sb_q.delete();
  endtask

  task automatic go_idle();
    abort = 1'b1;
    tick();
    abort = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //          base      len    slots nbytes nwr short long slot
    vecs[0] = '{16'h2000, 16'd4, 4'd3, 4, 4, 1'b0, 1'b0, 4'd1};
    vecs[1] = '{16'h3000, 16'd8, 4'd1, 3, 3, 1'b1, 1'b0, 4'd0};
    vecs[2] = '{16'h0100, 16'd0, 4'd2, 1, 1, 1'b0, 1'b0, 4'd1};
    vecs[3] = '{16'hFFFE, 16'd4, 4'd1, 4, 4, 1'b0, 1'b0, 4'd0};
    vecs[4] = '{16'h0600, 16'd2, 4'd2, 3, 2, 1'b0, 1'b1, 4'd1};
    vecs[5] = '{16'h0700, 16'd3, 4'd0, 3, 3, 1'b0, 1'b0, 4'd0};

    rst = 1'b1; start = 1'b0; abort = 1'b0; cfg_single = 1'b0;
    cfg_base = '0; cfg_len = '0; cfg_slots = '0;
    pix_valid = 1'b0; pix_sof = 1'b0; pix_eof = 1'b0; pix_data = '0;
    repeat (3) tick();
    chk("rst_busy", busy, 0);
    chk("rst_wr_en", dma_wr_en, 0);
    chk("rst_slot", slot_idx, 0);
    rst = 1'b0;
    tick();
    chk("idle_ready", pix_ready, 0);
    chk("idle_errs", {err_long, err_short}, 0);

    // single-frame table
    for (int v = 0; v < 6; v++) begin
      start_cfg(vecs[v].base, vecs[v].len, vecs[v].slots, 1'b1);
      chk($sformatf("v%0d_busy_armed", v), busy, 1);
      for (int i = 0; i < vecs[v].nbytes; i++)
        send(8'h40 + i[7:0], i == 0, i == vecs[v].nbytes - 1, i < vecs[v].nwr,
             vecs[v].base + i[15:0], i == vecs[v].nwr - 1, 1'b1);
      drain($sformatf("v%0d_writes", v));
      chk($sformatf("v%0d_busy_end", v), busy, 0);
      chk($sformatf("v%0d_err_short", v), err_short, vecs[v].short_e);
      chk($sformatf("v%0d_err_long", v), err_long, vecs[v].long_e);
      chk($sformatf("v%0d_slot", v), slot_idx, vecs[v].slot_e);
    end

    // nominal two-slot ring
    start_cfg(16'h1000, 16'd4, 4'd2, 1'b0);
    chk("nom_ready", pix_ready, 1);
    for (int i = 0; i < 4; i++)
      send(8'hAA + i[7:0], i == 0, i == 3, 1'b1, 16'h1000 + i[15:0], i == 3, 1'b1);
    drain("nom_f1");
    chk("nom_slot1", slot_idx, 1);
    chk("nom_busy", busy, 1);
    for (int i = 0; i < 4; i++)
      send(8'h11 + i[7:0], i == 0, i == 3, 1'b1, 16'h1004 + i[15:0], i == 3, 1'b1);
    drain("nom_f2");
    chk("nom_slot0", slot_idx, 0);
    chk("nom_errs", {err_long, err_short}, 0);
    go_idle();

    // address wrap, one slot, continuous
    start_cfg(16'hFFFE, 16'd4, 4'd1, 1'b0);
    for (int f = 0; f < 2; f++)
      for (int i = 0; i < 4; i++)
        send(8'h60 + i[7:0], i == 0, i == 3, 1'b1, 16'hFFFE + i[15:0], i == 3, 1'b1);
    drain("wrap_writes");
    chk("wrap_slot", slot_idx, 0);
    go_idle();

    // long frame: tail discarded through eof, an SOF inside the tail is ignored
    start_cfg(16'h0200, 16'd2, 4'd4, 1'b0);
    send(8'hD0, 1'b1, 1'b0, 1'b1, 16'h0200, 1'b0, 1'b1);
    send(8'hD1, 1'b0, 1'b0, 1'b1, 16'h0201, 1'b1, 1'b1);
    send(8'hD2, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
    send(8'hD3, 1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
    send(8'hD4, 1'b0, 1'b1, 1'b0, 16'h0, 1'b0, 1'b0);
    drain("long_writes");
    chk("long_err", err_long, 1);
    chk("long_slot", slot_idx, 1);
    send(8'hE0, 1'b1, 1'b0, 1'b1, 16'h0202, 1'b0, 1'b1);
    send(8'hE1, 1'b0, 1'b1, 1'b1, 16'h0203, 1'b1, 1'b1);
    drain("long_next");
    chk("long_slot2", slot_idx, 2);
    chk("long_sticky", {err_long, err_short}, 2'b10);
    go_idle();

    // SOF in the middle of a frame opens the next slot
    start_cfg(16'h0400, 16'd4, 4'd2, 1'b0);
    send(8'hA0, 1'b1, 1'b0, 1'b1, 16'h0400, 1'b0, 1'b1);
    send(8'hA1, 1'b0, 1'b0, 1'b1, 16'h0401, 1'b0, 1'b1);
    send(8'hC0, 1'b1, 1'b0, 1'b1, 16'h0404, 1'b0, 1'b0);
    send(8'hC1, 1'b0, 1'b0, 1'b1, 16'h0405, 1'b0, 1'b1);
    send(8'hC2, 1'b0, 1'b0, 1'b1, 16'h0406, 1'b0, 1'b1);
    send(8'hC3, 1'b0, 1'b1, 1'b1, 16'h0407, 1'b1, 1'b1);
    drain("midsof_writes");
    chk("midsof_short", err_short, 1);
    chk("midsof_slot", slot_idx, 0);
    go_idle();

    // abort mid-frame with a beat in the abort cycle
    start_cfg(16'h0800, 16'd4, 4'd2, 1'b0);
    send(8'h81, 1'b1, 1'b0, 1'b1, 16'h0800, 1'b0, 1'b1);
    send(8'h82, 1'b0, 1'b0, 1'b1, 16'h0801, 1'b0, 1'b1);
    abort = 1'b1; pix_valid = 1'b1; pix_data = 8'h83;
    tick();
    abort = 1'b0; pix_valid = 1'b0;
    chk("abort_busy", busy, 0);
    drain("abort_writes");
    chk("abort_slot", slot_idx, 0);
    chk("abort_errs", {err_long, err_short}, 0);

    // pre-SOF garbage, then reset mid-frame
    start_cfg(16'h0500, 16'd4, 4'd2, 1'b0);
    for (int i = 0; i < 3; i++)
      send(8'h90 + i[7:0], 1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
    drain("garbage_writes");
    chk("garbage_busy", busy, 1);
    send(8'hB0, 1'b1, 1'b0, 1'b1, 16'h0500, 1'b0, 1'b1);
    send(8'hB1, 1'b0, 1'b0, 1'b1, 16'h0501, 1'b0, 1'b1);
    rst = 1'b1; pix_valid = 1'b1; pix_data = 8'hB2;
    tick();
    chk("rstmid_wr_en", dma_wr_en, 0);
    chk("rstmid_addr", dma_wr_addr, 0);
    chk("rstmid_data", dma_wr_data, 0);
    chk("rstmid_done", frame_done, 0);
    chk("rstmid_slot", slot_idx, 0);
    chk("rstmid_busy", busy, 0);
    pix_data = 8'hB3;
    tick();
    rst = 1'b0;
    pix_data = 8'hB4;
    tick();
    tick();
    pix_valid = 1'b0;
    drain("rstmid_writes");
    chk("rstmid_errs", {err_long, err_short}, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
